term_writer: RTL

Terminal text-buffer write controller, directly downstream of the UART receive stage. It consumes filtered character strobes (`char`/`en`) and tracks a cursor over a ROWS×COLS character grid. It issues one-cell writes to the display's character RAM and implements line wrap, carriage-return newline and hardware scrolling. Scrolling uses a circular top-row pointer exported to the VGA renderer, so no RAM copy is ever performed.

---
 rtl/term_writer.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/term_writer.sv
// term_writer: terminal text-buffer write controller.
//
// Takes character strobes from the UART receive stage, keeps a cursor over a
// ROWS x COLS grid and issues single-cell writes to the display character RAM.
// Scrolling is done by advancing a circular top-row pointer (exported to the
// renderer) and blanking the row that becomes the new bottom line, so no RAM
// copy ever takes place.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   char, en             character code and its one-cycle strobe
//   wr_en/wr_addr/wr_data  registered RAM write port (addr = phys_row*COLS+col)
//   top_row              physical RAM row displayed at screen row 0
//   cur_col, cur_row     cursor position in screen coordinates
//   busy                 high while a clear write is on the RAM port (and
//                        from reset until the init clear completes)
//   dropped              one-cycle pulse when a character is discarded
//
// Assumes COLS >= 2 and ROWS >= 2.
module term_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   char,
  input  logic                         en,
  output logic                         wr_en,
  output logic [$clog2(ROWS*COLS)-1:0] wr_addr,
  output logic [7:0]                   wr_data,
  output logic [$clog2(ROWS)-1:0]      top_row,
  output logic [$clog2(COLS)-1:0]      cur_col,
  output logic [$clog2(ROWS)-1:0]      cur_row,
  output logic                         busy,
  output logic                         dropped
);

  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);

  localparam logic [AW-1:0] LAST_CELL    = AW'(CELLS - 1);
  localparam logic [AW-1:0] LAST_CLR_COL = AW'(COLS - 1);
  localparam logic [CW-1:0] LAST_COL     = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW     = RW'(ROWS - 1);
  localparam logic [7:0]    SPACE        = 8'h20;
  localparam logic [7:0]    CR           = 8'h0D;

  typedef enum logic [1:0] {INIT_CLEAR, IDLE, SCROLL_CLEAR} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   cnt, cnt_nxt;          // init: cell index; scroll: column
  logic [RW-1:0]   clr_row, clr_row_nxt;  // physical row being blanked
  logic            pend_vld, pend_vld_nxt;
  logic [7:0]      pend_ch, pend_ch_nxt;

  logic            wr_en_nxt, busy_nxt, dropped_nxt;
  logic [AW-1:0]   wr_addr_nxt;
  logic [7:0]      wr_data_nxt;
  logic [RW-1:0]   top_row_nxt, cur_row_nxt;
  logic [CW-1:0]   cur_col_nxt;

  logic            stall, src_vld, is_print, is_cr, do_nl;
  logic [7:0]      src_ch;
  logic [RW:0]     row_sum;
  logic [RW-1:0]   phys_row;

  function automatic logic [AW-1:0] row_base(input logic [RW-1:0] r);
    return AW'(r) * AW'(COLS);
  endfunction

  // Physical row under the cursor: (top_row + cur_row) mod ROWS.
  assign row_sum  = {1'b0, top_row} + {1'b0, cur_row};
  assign phys_row = (row_sum >= (RW+1)'(ROWS)) ? RW'(row_sum - (RW+1)'(ROWS))
                                                : row_sum[RW-1:0];

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    clr_row_nxt  = clr_row;
    pend_vld_nxt = pend_vld;
    pend_ch_nxt  = pend_ch;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    top_row_nxt  = top_row;
    cur_col_nxt  = cur_col;
    cur_row_nxt  = cur_row;
    busy_nxt     = busy;
    dropped_nxt  = 1'b0;
    src_vld      = 1'b0;
    src_ch       = char;
    is_print     = 1'b0;
    is_cr        = 1'b0;
    do_nl        = 1'b0;

    // Characters are only consumed in IDLE once the last clear write has
    // left the RAM port; any other cycle parks them in the pending slot.
    // The slot takes priority over a fresh strobe, which refills it.
    stall = (state != IDLE) || busy;
    if (!stall) begin
      if (pend_vld) begin
        src_vld      = 1'b1;
        src_ch       = pend_ch;
        pend_vld_nxt = en;
        if (en) pend_ch_nxt = char;
      end else if (en) begin
        src_vld = 1'b1;
        src_ch  = char;
      end
    end else if (en) begin
      if (!pend_vld) begin
        pend_vld_nxt = 1'b1;
        pend_ch_nxt  = char;
      end else begin
        dropped_nxt = 1'b1;
      end
    end

    case (state)
      INIT_CLEAR: begin
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = cnt;
        wr_data_nxt = SPACE;
        cnt_nxt     = cnt + AW'(1);
        if (cnt == LAST_CELL) state_nxt = IDLE;
      end

      SCROLL_CLEAR: begin
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = row_base(clr_row) + cnt;
        wr_data_nxt = SPACE;
        busy_nxt    = 1'b1;
        cnt_nxt     = cnt + AW'(1);
        if (cnt == LAST_CLR_COL) state_nxt = IDLE;
      end

      IDLE: begin
        if (busy) begin
          // Last clear write is visible this cycle; busy drops next.
          busy_nxt = 1'b0;
        end else if (src_vld) begin
          is_print = (src_ch >= 8'd32) && (src_ch <= 8'd126);
          is_cr    = (src_ch == CR);
          do_nl    = is_cr || (is_print && (cur_col == LAST_COL));

          if (is_print) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = row_base(phys_row) + AW'(cur_col);
            wr_data_nxt = src_ch;
            if (!do_nl) cur_col_nxt = cur_col + CW'(1);
          end

          if (do_nl) begin
            cur_col_nxt = '0;
            if (cur_row != LAST_ROW) begin
              cur_row_nxt = cur_row + RW'(1);
            end else begin
              top_row_nxt = (top_row == LAST_ROW) ? '0 : top_row + RW'(1);
              clr_row_nxt = top_row;
              state_nxt   = SCROLL_CLEAR;
              if (is_cr) begin
                // RAM port is free, so column 0 of the clear goes out now.
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = row_base(top_row);
                wr_data_nxt = SPACE;
                busy_nxt    = 1'b1;
                cnt_nxt     = AW'(1);
              end else begin
                // Port is carrying the character; clear starts next cycle.
                cnt_nxt = '0;
              end
            end
          end
        end
      end

      default: state_nxt = INIT_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT_CLEAR;
      cnt      <= '0;
      clr_row  <= '0;
      pend_vld <= 1'b0;
      pend_ch  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= SPACE;
      top_row  <= '0;
      cur_col  <= '0;
      cur_row  <= '0;
      busy     <= 1'b1;
      dropped  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      clr_row  <= clr_row_nxt;
      pend_vld <= pend_vld_nxt;
      pend_ch  <= pend_ch_nxt;
      wr_en    <= wr_en_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
      top_row  <= top_row_nxt;
      cur_col  <= cur_col_nxt;
      cur_row  <= cur_row_nxt;
      busy     <= busy_nxt;
      dropped  <= dropped_nxt;
    end
  end

endmodule
